// File: rtl/tetris_pkg.sv
// Shared board geometry, colour codes, palette and clear-sequencer state type
// for the board pixel generator and its cell storage.
package tetris_pkg;

  localparam int BOARD_ROWS  = 20;
  localparam int BOARD_COLS  = 10;
  localparam int CELL_PX     = 24;
  localparam int BOARD_CELLS = BOARD_ROWS * BOARD_COLS;
  localparam int ADDR_W      = 8;

  typedef enum logic [2:0] {
    C_EMPTY   = 3'd0,
    C_RED     = 3'd1,
    C_ORANGE  = 3'd2,
    C_YELLOW  = 3'd3,
    C_GREEN   = 3'd4,
    C_BLUE    = 3'd5,
    C_CYAN    = 3'd6,
    C_MAGENTA = 3'd7
  } color_t;

  // Entry 0 sits in the least significant 24 bits.
  localparam logic [7:0][23:0] PALETTE = {
    24'hFF00FF, 24'h00FFFF, 24'h0000FF, 24'h00FF00,
    24'hFFFF00, 24'hFFA500, 24'hFF0000, 24'h000000
  };

  localparam logic [23:0] OFF_BOARD_RGB = 24'h404040;
  localparam logic [23:0] GRID_RGB      = 24'h202020;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  // Row-major linear cell index.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                  input logic [3:0] col);
    return ADDR_W'(row) * ADDR_W'(BOARD_COLS) + ADDR_W'(col);
  endfunction

  function automatic logic [23:0] palette_rgb(input color_t c);
    return PALETTE[c];
  endfunction

endpackage

// File: rtl/board_pixel_gen_if.sv
// Game-logic cell write channel into the board pixel generator.
interface board_pixel_gen_if;
   // A write transfers on a rising edge where wr_valid and wr_ready are both
   // high; wr_row/wr_col/wr_color are held stable while wr_valid is high, and
   // wr_ready does not depend on wr_valid.
   logic       wr_valid;
   logic [4:0] wr_row;
   logic [3:0] wr_col;
   logic [2:0] wr_color;
   logic       wr_ready;

   modport master (
      output wr_valid, wr_row, wr_col, wr_color,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_row, wr_col, wr_color,
      output wr_ready
   );
endinterface

// File: rtl/board_ram.sv
// 20x10 board of 3-bit cells with one write port, one registered read port
// and a sequencer that zeroes the board one cell per cycle.
module board_ram
   import tetris_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear_start,
   input  logic              wr_en,
   input  logic [4:0]        wr_row,
   input  logic [3:0]        wr_col,
   input  color_t            wr_color,
   input  logic [ADDR_W-1:0] rd_addr,
   output color_t            rd_data,
   output logic              busy,
   output clr_state_t        state
);

   color_t            cells [BOARD_CELLS];
   clr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              clr_we;
   logic              wr_hit;
   logic [ADDR_W-1:0] wr_addr;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_we     = 1'b0;
      case (state_q)
         CLR_IDLE: begin
            if (clear_start) begin
               state_d    = CLR_RUN;
               clr_addr_d = '0;
            end
         end
         CLR_RUN: begin
            clr_we = 1'b1;
            if (clr_addr_q == ADDR_W'(BOARD_CELLS - 1)) state_d = CLR_IDLE;
            else clr_addr_d = clr_addr_q + 1'b1;
         end
         default: state_d = CLR_IDLE;
      endcase
   end

   // A clear request wins over a same-cycle write; off-board writes are dropped.
   assign wr_addr = cell_addr(wr_row, wr_col);
   assign wr_hit  = wr_en && (state_q == CLR_IDLE) && !clear_start &&
                    (wr_row < 5'(BOARD_ROWS)) && (wr_col < 4'(BOARD_COLS));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= CLR_IDLE;
         clr_addr_q <= '0;
         rd_data    <= C_EMPTY;
         for (int i = 0; i < BOARD_CELLS; i++) cells[i] <= C_EMPTY;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         // Read samples the pre-write contents, so a same-cycle collision sees old data.
         rd_data    <= (rd_addr < ADDR_W'(BOARD_CELLS)) ? cells[rd_addr] : C_EMPTY;
         if (clr_we) cells[clr_addr_q] <= C_EMPTY;
         else if (wr_hit) cells[wr_addr] <= wr_color;
      end
   end

   assign busy  = (state_q == CLR_RUN);
   assign state = state_q;

endmodule

// File: rtl/board_pixel_gen.sv
// Board pixel generator: maps a pixel to a board cell, reads it and runs the
// palette with a fixed two-cycle latency. Define BOARD_GRID_EN for grid lines.
module board_pixel_gen
   import tetris_pkg::*;
#(
   parameter int BOARD_X0 = 200,
   parameter int BOARD_Y0 = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   input  logic              pix_valid,
   board_pixel_gen_if.slave  wr,
   input  logic              clear_start,
   output logic              busy,
   output logic [7:0]        RED,
   output logic [7:0]        GREEN,
   output logic [7:0]        BLUE,
   output logic              vga_blank,
   output clr_state_t        clear_state
);

   int                dx, dy;
   logic              in_board;
   logic [7:0]        dx_px;
   logic [8:0]        dy_px;
   logic [3:0]        col;
   logic [4:0]        row;
   logic [ADDR_W-1:0] rd_addr;
   color_t            rd_cell;
   logic              s1_valid, s1_in_board;
   logic [23:0]       pixel_rgb, rgb_q;
   logic              blank_q;
`ifdef BOARD_GRID_EN
   logic              on_grid, s1_grid;
`endif

   always_comb begin
      dx       = int'(pix_x) - BOARD_X0;
      dy       = int'(pix_y) - BOARD_Y0;
      in_board = (dx >= 0) && (dx < BOARD_COLS * CELL_PX) &&
                 (dy >= 0) && (dy < BOARD_ROWS * CELL_PX);
      // Once in-board, the offsets fit in 8 and 9 bits.
      dx_px    = dx[7:0];
      dy_px    = dy[8:0];
      col      = 4'(dx_px / 8'(CELL_PX));
      row      = 5'(dy_px / 9'(CELL_PX));
      rd_addr  = in_board ? cell_addr(row, col) : '0;
   end

`ifdef BOARD_GRID_EN
   assign on_grid = (dx_px % 8'(CELL_PX) == 8'd0) || (dy_px % 9'(CELL_PX) == 9'd0);
`endif

   assign wr.wr_ready = ~busy;

   board_ram u_board_ram (
      .clock       (clock),
      .reset       (reset),
      .clear_start (clear_start),
      .wr_en       (wr.wr_valid & wr.wr_ready),
      .wr_row      (wr.wr_row),
      .wr_col      (wr.wr_col),
      .wr_color    (color_t'(wr.wr_color)),
      .rd_addr     (rd_addr),
      .rd_data     (rd_cell),
      .busy        (busy),
      .state       (clear_state)
   );

   always_comb begin
      pixel_rgb = 24'h000000;
      if (s1_valid) begin
         if (!s1_in_board) pixel_rgb = OFF_BOARD_RGB;
`ifdef BOARD_GRID_EN
         else if (s1_grid) pixel_rgb = GRID_RGB;
`endif
         else pixel_rgb = palette_rgb(rd_cell);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid    <= 1'b0;
         s1_in_board <= 1'b0;
`ifdef BOARD_GRID_EN
         s1_grid     <= 1'b0;
`endif
         rgb_q       <= '0;
         blank_q     <= 1'b0;
      end else begin
         s1_valid    <= pix_valid;
         s1_in_board <= in_board;
`ifdef BOARD_GRID_EN
         s1_grid     <= on_grid;
`endif
         rgb_q       <= pixel_rgb;
         blank_q     <= s1_valid;
      end
   end

   assign RED       = rgb_q[23:16];
   assign GREEN     = rgb_q[15:8];
   assign BLUE      = rgb_q[7:0];
   assign vga_blank = blank_q;

endmodule
